// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// No logic: types, BCD limits and a combinational increment helper.
// Backpressure: not applicable.
//   Contents: sw_state_e (FSM states), bcd_t (4-bit BCD digit),
//             sw_time_t (M:SS display value), time_inc (BCD +1 s with 9:59 wrap).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_LIMIT_NINE = 4'd9;
    localparam bcd_t BCD_LIMIT_FIVE = 4'd5;

    typedef struct packed {
        bcd_t min;
        bcd_t tens;
        bcd_t units;
    } sw_time_t;

    // One-second BCD increment; 9:59 rolls over to 0:00.
    function automatic sw_time_t time_inc(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.units == BCD_LIMIT_NINE) begin
            r.units = 4'd0;
            if (t.tens == BCD_LIMIT_FIVE) begin
                r.tens = 4'd0;
                if (t.min == BCD_LIMIT_NINE) begin
                    r.min = 4'd0;
                end else begin
                    r.min = t.min + 4'd1;
                end
            end else begin
                r.tens = t.tens + 4'd1;
            end
        end else begin
            r.units = t.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, press pulse.
// Latency: press_o pulses DEBOUNCE_CYCLES+3 cycles after btn_i rises and stays high.
// Backpressure: none; press_o is a single-cycle strobe, release gives no pulse.
//   Ports: clk_i, rst_i (sync, active-high), btn_i (raw, async), press_o (1-cycle pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       vld_q;
    logic             armed_q, armed_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The debounced level only flips after the synchronized input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A button held through reset must be seen released once (after the
    // synchronizer has refilled with real samples) before presses count.
    assign armed_d = armed_q | (vld_q[1] & ~sync2_q);
    assign press_d = stable_q & ~stable_dly_q & armed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            vld_q        <= 2'b00;
            armed_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            vld_q        <= {vld_q[0], 1'b1};
            armed_q      <= armed_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// M:SS stopwatch with start/stop and lap/clear buttons, BCD display outputs.
// Latency: outputs registered; SEC_PULSE and the new count appear one cycle after the prescaler wraps.
// Backpressure: none; button events are single-cycle pulses, START wins over LAP.
//   Ports: CLK, RST (sync, active-high), BTN_START/BTN_LAP (raw buttons),
//          DISP_MIN/DISP_TENS/DISP_UNITS (BCD), RUNNING, LAP_ACTIVE, SEC_PULSE.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 25000000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_LAP,
    output logic [3:0] DISP_MIN,
    output logic [3:0] DISP_TENS,
    output logic [3:0] DISP_UNITS,
    output logic       RUNNING,
    output logic       LAP_ACTIVE,
    output logic       SEC_PULSE
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    sw_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    sw_time_t    count_q, count_d;
    sw_time_t    lap_q, lap_d;
    sw_time_t    disp_q, disp_d;
    logic        running_q, lap_active_q, sec_pulse_q;
    logic        start_ev, lap_ev;
    logic        counting, tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_i   (BTN_START),
        .press_o (start_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_i   (BTN_LAP),
        .press_o (lap_ev)
    );

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        lap_d   = lap_q;

        // Counting is resolved before the transition, so a tick landing on
        // the START that pauses the watch is still credited.
        if (counting) begin
            if (tick) begin
                presc_d = '0;
                count_d = time_inc(count_q);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                count_d = '0;
                if (start_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_ev) begin
                    state_d = ST_PAUSE;
                end else if (lap_ev) begin
                    state_d = ST_LAP;
                    lap_d   = count_d;
                end
            end
            ST_LAP: begin
                if (start_ev)    state_d = ST_PAUSE;
                else if (lap_ev) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (start_ev) begin
                    state_d = ST_RUN;
                end else if (lap_ev) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        disp_d = (state_d == ST_LAP) ? lap_d : count_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            count_q      <= '0;
            lap_q        <= '0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            sec_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
            running_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
            lap_active_q <= (state_d == ST_LAP);
            sec_pulse_q  <= tick;
        end
    end

    assign DISP_MIN   = disp_q.min;
    assign DISP_TENS  = disp_q.tens;
    assign DISP_UNITS = disp_q.units;
    assign RUNNING    = running_q;
    assign LAP_ACTIVE = lap_active_q;
    assign SEC_PULSE  = sec_pulse_q;

endmodule
